// File: rtl/inport_fifo_ctrl_if.sv
// ============================================================================
// Module   : inport_fifo_ctrl_if
// Brief    : Producer/datapath handshake bundle for the in-port FIFO controller.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface inport_fifo_ctrl_if #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 8,
  parameter int CHANNELS = 2
);
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int NW = $clog2(DEPTH) + 1;

  logic [CHANNELS-1:0]       ext_valid;
  logic [CHANNELS*WIDTH-1:0] ext_data;
  logic [CHANNELS-1:0]       ext_ready;
  logic                      rd_pop;
  logic                      err_clr;
  logic [WIDTH-1:0]          inport_data;
  logic [CW-1:0]             inport_chan;
  logic                      inport_valid;
  logic [NW-1:0]             fifo_count;
  logic                      fifo_full;
  logic                      underflow;

  modport master (
    output ext_valid, ext_data, rd_pop, err_clr,
    input  ext_ready, inport_data, inport_chan, inport_valid,
           fifo_count, fifo_full, underflow
  );

  modport slave (
    input  ext_valid, ext_data, rd_pop, err_clr,
    output ext_ready, inport_data, inport_chan, inport_valid,
           fifo_count, fifo_full, underflow
  );
endinterface

`default_nettype wire

// File: rtl/inport_fifo_ctrl.sv
// ============================================================================
// Module   : inport_fifo_ctrl
// Brief    : Round-robin arbiter of CHANNELS producers into one FWFT FIFO
//            feeding the datapath in-port, with channel tag and sticky underflow.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module inport_fifo_ctrl #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 8,
  parameter int CHANNELS = 2
) (
  input  wire logic        clk,
  input  wire logic        rst,
  inport_fifo_ctrl_if.slave bus
);
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int AW = $clog2(DEPTH);
  localparam int NW = AW + 1;

  logic [WIDTH-1:0]    r_mem_data [DEPTH];
  logic [CW-1:0]       r_mem_chan [DEPTH];
  logic [AW-1:0]       r_head;
  logic [AW-1:0]       r_tail;
  logic [NW-1:0]       r_count;
  logic [CW-1:0]       r_rr;
  logic                r_uf;

  logic                w_full;
  logic                w_empty;
  logic                w_push;
  logic                w_pop;
  logic [CHANNELS-1:0] w_ready;
  logic [CW-1:0]       w_gnt;
  logic [CW-1:0]       w_idx;
  logic [CW-1:0]       w_rr_next;
  logic [WIDTH-1:0]    w_push_data;

  assign w_full  = (r_count == NW'(DEPTH));
  assign w_empty = (r_count == '0);

  // Scan from farthest to nearest so the channel closest to r_rr wins last.
  always_comb begin
    int idx;
    w_ready = '0;
    w_gnt   = '0;
    w_idx   = '0;
    idx     = 0;
    if (!rst && !w_full) begin
      for (int k = CHANNELS - 1; k >= 0; k--) begin
        idx = int'(r_rr) + k;
        if (idx >= CHANNELS) idx = idx - CHANNELS;
        w_idx = CW'(idx);
        if (bus.ext_valid[w_idx]) begin
          w_ready        = '0;
          w_ready[w_idx] = 1'b1;
          w_gnt          = w_idx;
        end
      end
    end
  end

  assign w_push      = |(bus.ext_valid & w_ready);
  assign w_pop       = bus.rd_pop && !w_empty;
  assign w_push_data = bus.ext_data[w_gnt*WIDTH +: WIDTH];
  assign w_rr_next   = (w_gnt == CW'(CHANNELS - 1)) ? '0 : w_gnt + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_rr    <= '0;
      r_uf    <= 1'b0;
    end else begin
      if (w_push) begin
        r_tail <= r_tail + 1'b1;
        r_rr   <= w_rr_next;
      end
      if (w_pop) r_head <= r_head + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + NW'(1);
      else if (!w_push && w_pop) r_count <= r_count - NW'(1);
      // A fresh underflow outranks a same-cycle clear.
      if (bus.rd_pop && w_empty) r_uf <= 1'b1;
      else if (bus.err_clr)      r_uf <= 1'b0;
    end
  end

  // Storage needs no reset: entries are only visible through the counted window.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_data[r_tail] <= w_push_data;
      r_mem_chan[r_tail] <= w_gnt;
    end
  end

  assign bus.ext_ready    = w_ready;
  assign bus.inport_valid = !w_empty;
  assign bus.inport_data  = w_empty ? '0 : r_mem_data[r_head];
  assign bus.inport_chan  = w_empty ? '0 : r_mem_chan[r_head];
  assign bus.fifo_count   = r_count;
  assign bus.fifo_full    = w_full;
  assign bus.underflow    = r_uf;
endmodule

`default_nettype wire

// File: tb/tb_inport_fifo_ctrl.sv
// ============================================================================
// Module   : tb_inport_fifo_ctrl
// Brief    : Self-checking bench: queue-based reference model plus directed
//            and randomized stimulus for inport_fifo_ctrl.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_inport_fifo_ctrl;
  localparam int W = 32;
  localparam int D = 8;
  localparam int C = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  inport_fifo_ctrl_if #(.WIDTH(W), .DEPTH(D), .CHANNELS(C)) bus ();
  inport_fifo_ctrl #(.WIDTH(W), .DEPTH(D), .CHANNELS(C)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [W-1:0] d;
    int           ch;
  } ent_t;

  ent_t q[$];
  int   rr;
  bit   uf;
  int   lastg;
  int   n_pass;
  int   n_tot;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Grant rule: nothing when in reset or full, else first valid at/after rr.
  function automatic int pick(input logic [C-1:0] v);
    if (rst || q.size() == D) return -1;
    for (int k = 0; k < C; k++) begin
      if (v[(rr + k) % C]) return (rr + k) % C;
    end
    return -1;
  endfunction

  task automatic drive(input logic [C-1:0] v, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic pop, input logic clr);
    bus.ext_valid = v;
    bus.ext_data  = {b, a};
    bus.rd_pop    = pop;
    bus.err_clr   = clr;
  endtask

  // Compare at the falling edge, then advance the model with the inputs the
  // rising edge is about to sample.
  task automatic cycle();
    int g;
    @(negedge clk);
    g = pick(bus.ext_valid);
    chk("ext_ready", 64'(bus.ext_ready), (g < 0) ? 64'd0 : (64'd1 << g));
    chk("inport_valid", 64'(bus.inport_valid), 64'(q.size() > 0));
    chk("inport_data", 64'(bus.inport_data), (q.size() > 0) ? 64'(q[0].d) : 64'd0);
    chk("inport_chan", 64'(bus.inport_chan), (q.size() > 0) ? 64'(q[0].ch) : 64'd0);
    chk("fifo_count", 64'(bus.fifo_count), 64'(q.size()));
    chk("fifo_full", 64'(bus.fifo_full), 64'(q.size() == D));
    chk("underflow", 64'(bus.underflow), 64'(uf));
    lastg = g;
    if (!rst) begin
      if (bus.rd_pop && q.size() == 0) uf = 1'b1;
      else if (bus.err_clr)            uf = 1'b0;
      if (bus.rd_pop && q.size() > 0) void'(q.pop_front());
      if (g >= 0) begin
        q.push_back('{bus.ext_data[g*W +: W], g});
        rr = (g + 1) % C;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [W-1:0] wa;
    logic [W-1:0] wb;
    n_pass = 0;
    n_tot  = 0;
    rr     = 0;
    uf     = 1'b0;
    lastg  = -1;

    // Reset held with every channel offering.
    drive(2'b11, 32'h1, 32'h2, 1'b0, 1'b0);
    repeat (2) cycle();
    chk("rst_ready", 64'(bus.ext_ready), 64'd0);
    chk("rst_count", 64'(bus.fifo_count), 64'd0);
    rst = 1'b0;

    // Single word from channel 0.
    drive(2'b01, 32'h88, 32'h0, 1'b0, 1'b0);
    cycle();
    drive(2'b00, 32'h0, 32'h0, 1'b0, 1'b0);
    chk("t2_valid", 64'(bus.inport_valid), 64'd1);
    chk("t2_data", 64'(bus.inport_data), 64'h88);
    chk("t2_chan", 64'(bus.inport_chan), 64'd0);
    drive(2'b00, 32'h0, 32'h0, 1'b1, 1'b0);
    cycle();
    drive(2'b00, 32'h0, 32'h0, 1'b0, 1'b0);
    chk("t2_pop_valid", 64'(bus.inport_valid), 64'd0);
    chk("t2_pop_count", 64'(bus.fifo_count), 64'd0);

    // Asynchronous reset mid-cycle with data in flight.
    drive(2'b11, 32'h11, 32'h22, 1'b0, 1'b0);
    repeat (2) cycle();
    #2 rst = 1'b1;
    #1;
    chk("arst_count", 64'(bus.fifo_count), 64'd0);
    chk("arst_valid", 64'(bus.inport_valid), 64'd0);
    chk("arst_data", 64'(bus.inport_data), 64'd0);
    chk("arst_ready", 64'(bus.ext_ready), 64'd0);
    q.delete();
    rr = 0;
    uf = 1'b0;
    cycle();
    rst = 1'b0;

    // Round-robin with both channels held valid.
    wa = 32'hA0;
    wb = 32'hB0;
    for (int i = 0; i < 4; i++) begin
      drive(2'b11, wa, wb, 1'b0, 1'b0);
      cycle();
      if (lastg == 0) wa++;
      if (lastg == 1) wb++;
    end
    drive(2'b00, 32'h0, 32'h0, 1'b0, 1'b0);
    chk("rr_head0", 64'(bus.inport_data), 64'hA0);
    chk("rr_chan0", 64'(bus.inport_chan), 64'd0);
    drive(2'b00, 32'h0, 32'h0, 1'b1, 1'b0);
    cycle();
    chk("rr_head1", 64'(bus.inport_data), 64'hB0);
    chk("rr_chan1", 64'(bus.inport_chan), 64'd1);
    cycle();
    chk("rr_head2", 64'(bus.inport_data), 64'hA1);
    cycle();
    chk("rr_head3", 64'(bus.inport_data), 64'hB1);
    cycle();

    // Fill to full, then stream through the pointer wrap (20 words total).
    wa = 32'h100;
    for (int i = 0; i < 8; i++) begin
      drive(2'b01, wa, 32'h0, 1'b0, 1'b0);
      cycle();
      if (lastg == 0) wa++;
    end
    drive(2'b01, wa, 32'h0, 1'b0, 1'b0);
    chk("fill_count", 64'(bus.fifo_count), 64'd8);
    chk("fill_full", 64'(bus.fifo_full), 64'd1);
    chk("fill_ready", 64'(bus.ext_ready), 64'd0);
    drive(2'b01, wa, 32'h0, 1'b1, 1'b0);
    cycle();
    chk("fill_ready_back", 64'(bus.ext_ready), 64'd1);
    for (int i = 0; i < 12; i++) begin
      drive(2'b01, wa, 32'h0, 1'b1, 1'b0);
      cycle();
      if (lastg == 0) wa++;
    end
    chk("fill_words", 64'(wa), 64'h100 + 64'd20);
    drive(2'b00, 32'h0, 32'h0, 1'b1, 1'b0);
    while (q.size() > 0) cycle();

    // Push and pop together at count 3.
    for (int i = 0; i < 3; i++) begin
      drive(2'b10, 32'h0, 32'h300 + W'(i), 1'b0, 1'b0);
      cycle();
    end
    drive(2'b10, 32'h0, 32'h303, 1'b1, 1'b0);
    cycle();
    chk("pp_count", 64'(bus.fifo_count), 64'd3);
    chk("pp_head", 64'(bus.inport_data), 64'h301);

    // Underflow set, clear, and clear racing a new underflow.
    drive(2'b00, 32'h0, 32'h0, 1'b1, 1'b0);
    repeat (4) cycle();
    chk("uf_set", 64'(bus.underflow), 64'd1);
    chk("uf_data", 64'(bus.inport_data), 64'd0);
    drive(2'b00, 32'h0, 32'h0, 1'b0, 1'b1);
    cycle();
    chk("uf_clr", 64'(bus.underflow), 64'd0);
    drive(2'b00, 32'h0, 32'h0, 1'b1, 1'b1);
    cycle();
    chk("uf_clr_race", 64'(bus.underflow), 64'd1);
    drive(2'b00, 32'h0, 32'h0, 1'b0, 1'b1);
    cycle();

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      drive(C'($urandom), $urandom, $urandom,
            ($urandom_range(0, 99) < 40), ($urandom_range(0, 99) < 5));
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule

`default_nettype wire
